// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Optional watchdog on the memory handshake: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WIDTH-1:0]      m0_wdata_i,
    input  logic                  m0_wr_rd_i,
    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    output logic [WIDTH-1:0]      m0_rdata_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WIDTH-1:0]      m1_wdata_i,
    input  logic                  m1_wr_rd_i,
    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    output logic [WIDTH-1:0]      m1_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic                  mem_wr_rd_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
    logic                    mem_wr_rd_q, mem_wr_rd_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    m0_ready_q, m0_ready_d;
    logic                    m1_ready_q, m1_ready_d;
    logic [WIDTH-1:0]        m0_rdata_q, m0_rdata_d;
    logic [WIDTH-1:0]        m1_rdata_q, m1_rdata_d;
    logic                    pick;

    // On a tie the requester that was not granted last wins.
    assign pick = (m0_valid_i && m1_valid_i) ? ~last_q : m1_valid_i;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    assign err_o = err_q;
`else
    // TIMEOUT only matters to the watchdog; without it err_o is constant 0.
    assign err_o = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_rd_d = mem_wr_rd_q;
        mem_valid_d = mem_valid_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    gnt_d       = pick;
                    last_d      = pick;
                    mem_addr_d  = pick ? m1_addr_i  : m0_addr_i;
                    mem_wdata_d = pick ? m1_wdata_i : m0_wdata_i;
                    mem_wr_rd_d = pick ? m1_wr_rd_i : m0_wr_rd_i;
                    mem_valid_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    if (!mem_wr_rd_q) begin
                        if (gnt_q) m1_rdata_d = mem_rdata_i;
                        else       m0_rdata_d = mem_rdata_i;
                    end
                    m0_ready_d  = ~gnt_q;
                    m1_ready_d  = gnt_q;
                    state_d     = DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abort: complete the requester with err_o, rdata untouched.
                    mem_valid_d = 1'b0;
                    m0_ready_d  = ~gnt_q;
                    m1_ready_d  = gnt_q;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (!mem_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_rd_q <= 1'b0;
            mem_valid_q <= 1'b0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_rd_q <= mem_wr_rd_d;
            mem_valid_q <= mem_valid_d;
            m0_ready_q  <= m0_ready_d;
            m1_ready_q  <= m1_ready_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wr_rd_o = mem_wr_rd_q;
    assign mem_valid_o = mem_valid_q;
    assign m0_ready_o  = m0_ready_q;
    assign m1_ready_o  = m1_ready_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

endmodule
